gmrr_interp_reader: RTL and testbench

- Read-side engine for the GMRR sample buffer, a dual-port RAM with a registered read that returns both word[addr] and word[addr+1].
- Walks a fractional read position through the buffer using a phase accumulator. Fetches the two adjacent complex samples, linearly interpolates them, and emits one AXI-stream sample per position.
- Publishes its consumed pointer back to the upstream writer for flow control.

---
 rtl/gmrr_interp_reader_if.sv | 22 ++
 rtl/gmrr_interp_reader.sv | 157 +++++++++++++++
 tb/tb_gmrr_interp_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gmrr_interp_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : gmrr_interp_reader_if
//  Purpose  : AXI-stream style sample channel carried out of the GMRR
//             interpolating reader. Each beat is one complex sample {I,Q}.
//  Signals  : tdata  [2*SWIDTH-1:0]  interpolated sample, I in the upper half
//             tvalid                 sample available
//             tready                 consumer accepts the sample
//  Modports : master (producer side), slave (consumer side)
//  Revision : 1.0  initial release
// ============================================================================
interface gmrr_interp_reader_if #(
  parameter int SWIDTH = 16
) ();
  logic [2*SWIDTH-1:0] tdata;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/gmrr_interp_reader.sv
`default_nettype none
// ============================================================================
//  Module   : gmrr_interp_reader
//  Purpose  : Read-side engine for the GMRR sample buffer. A phase accumulator
//             walks a fractional read position through the buffer; for each
//             position the two neighbouring complex samples are fetched and
//             linearly interpolated, and one stream beat is emitted.
//  Ports    : clk, reset, clear    clock, sync active-high reset / soft reset
//             step     [FW:0]      position increment, unsigned 1.FRAC_WIDTH
//             wr_ptr   [AW:0]      writer pointer (with wrap bit)
//             rd_ptr   [AW:0]      integer part of read position
//             ram_en, ram_addr     buffer read port request
//             ram_doa, ram_doa_next  word[addr] / word[addr+1], one cycle later
//             out_if (master)      interpolated {I,Q} stream
//  Revision : 1.0  initial release
// ============================================================================
module gmrr_interp_reader #(
  parameter int AWIDTH     = 9,
  parameter int SWIDTH     = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [FRAC_WIDTH:0]   step,
  input  logic [AWIDTH:0]       wr_ptr,
  output logic [AWIDTH:0]       rd_ptr,
  output logic                  ram_en,
  output logic [AWIDTH-1:0]     ram_addr,
  input  logic [2*SWIDTH-1:0]   ram_doa,
  input  logic [2*SWIDTH-1:0]   ram_doa_next,
  gmrr_interp_reader_if.master  out_if
);

  localparam int PW = AWIDTH + 1 + FRAC_WIDTH;   // position width
  localparam int MW = SWIDTH + FRAC_WIDTH + 2;   // product width

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WRAP = 3'd2,
    S_RD2  = 3'd3,
    S_MUL  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         pos_q;
  logic [FRAC_WIDTH:0]   step_q;
  logic [2*SWIDTH-1:0]   s0_q;
  logic [2*SWIDTH-1:0]   s1_q;
  logic [2*SWIDTH-1:0]   tdata_q;
  logic                  tvalid_q;

  logic                  rst_w;
  logic [AWIDTH:0]       ipart_w;
  logic [FRAC_WIDTH-1:0] frac_w;
  logic [AWIDTH:0]       occ_w;
  logic                  issue_w;

  // y = a + ((b - a) * f) >>> FRAC_WIDTH. The difference needs one extra bit;
  // f is zero-extended so it multiplies as a non-negative value. The result
  // always lies between a and b, so keeping the low SWIDTH bits is exact.
  function automatic logic [SWIDTH-1:0] lerp(
    input logic [SWIDTH-1:0]     a,
    input logic [SWIDTH-1:0]     b,
    input logic [FRAC_WIDTH-1:0] f
  );
    logic signed [SWIDTH:0] diff;
    logic signed [MW-1:0]   prod;
    logic signed [MW-1:0]   shifted;
    diff    = signed'({b[SWIDTH-1], b}) - signed'({a[SWIDTH-1], a});
    prod    = MW'(diff) * MW'(signed'({1'b0, f}));
    shifted = prod >>> FRAC_WIDTH;
    return a + shifted[SWIDTH-1:0];
  endfunction

  assign rst_w   = reset | clear;
  assign ipart_w = pos_q[PW-1:FRAC_WIDTH];
  assign frac_w  = pos_q[FRAC_WIDTH-1:0];
  assign occ_w   = wr_ptr - ipart_w;
  // Two samples must be present: the interpolation needs word[ipart+1].
  assign issue_w = (state_q == S_IDLE) && (occ_w > (AWIDTH+1)'(1));

  assign rd_ptr        = ipart_w;
  assign out_if.tdata  = tdata_q;
  assign out_if.tvalid = tvalid_q;

  // The RAM read is registered, so the request must be presented in the
  // deciding cycle itself for the data to land in the following state.
  always_comb begin
    ram_en   = 1'b0;
    ram_addr = '0;
    if (!rst_w) begin
      if (issue_w) begin
        ram_en   = 1'b1;
        ram_addr = ipart_w[AWIDTH-1:0];
      end else if (state_q == S_WRAP) begin
        // word[addr+1] is not available past the last address; refetch
        // the successor from address 0.
        ram_en   = 1'b1;
        ram_addr = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_w) begin
      state_q  <= S_IDLE;
      pos_q    <= '0;
      step_q   <= step;
      s0_q     <= '0;
      s1_q     <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue_w) begin
            state_q <= (ipart_w[AWIDTH-1:0] == '1) ? S_WRAP : S_RD;
          end
        end
        S_RD: begin
          s0_q    <= ram_doa;
          s1_q    <= ram_doa_next;
          state_q <= S_MUL;
        end
        S_WRAP: begin
          s0_q    <= ram_doa;
          state_q <= S_RD2;
        end
        S_RD2: begin
          s1_q    <= ram_doa;
          state_q <= S_MUL;
        end
        S_MUL: begin
          tdata_q  <= {lerp(s0_q[2*SWIDTH-1:SWIDTH], s1_q[2*SWIDTH-1:SWIDTH], frac_w),
                       lerp(s0_q[SWIDTH-1:0],        s1_q[SWIDTH-1:0],        frac_w)};
          tvalid_q <= 1'b1;
          state_q  <= S_OUT;
        end
        S_OUT: begin
          if (out_if.tready) begin
            tvalid_q <= 1'b0;
            pos_q    <= pos_q + PW'(step_q);
            state_q  <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gmrr_interp_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gmrr_interp_reader
//  Purpose  : Self-checking bench for gmrr_interp_reader (16-entry buffer).
//             A behavioural model tracks the absolute read position and the
//             list of written samples and predicts every output beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gmrr_interp_reader;
  localparam int AW    = 4;
  localparam int SW    = 16;
  localparam int FW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, clear;
  logic [FW:0]   step;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_doa, ram_doa_next;

  gmrr_interp_reader_if #(.SWIDTH(SW)) axis ();

  gmrr_interp_reader #(.AWIDTH(AW), .SWIDTH(SW), .FRAC_WIDTH(FW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .step(step),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_doa(ram_doa), .ram_doa_next(ram_doa_next), .out_if(axis)
  );

  always #5 clk = ~clk;

  // Buffer model: registered dual read; successor of the last word is poison.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_doa      <= mem[ram_addr];
      ram_doa_next <= (ram_addr == AW'(DEPTH-1)) ? 32'hDEAD_BEEF : mem[ram_addr + 1'b1];
    end
  end

  // Bus monitor
  int   cyc = 0, issue_cyc = 0, wrap_reads = 0, en_count = 0, en_while_valid = 0;
  logic en_prev = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_prev <= ram_en;
    if (ram_en) en_count <= en_count + 1;
    if (ram_en && !en_prev) issue_cyc <= cyc;
    if (ram_en && en_prev && ram_addr == '0) wrap_reads <= wrap_reads + 1;
    if (ram_en && axis.tvalid) en_while_valid <= en_while_valid + 1;
  end

  // Reference model state
  longint      pos_m;
  logic [FW:0] step_m;
  logic [31:0] samp [$];
  int          wr_abs;
  int          ncmp = 0, nfail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lerp_m(input logic [15:0] a, input logic [15:0] b, input int fr);
    longint la, lb, d;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    d  = (lb - la) * longint'(fr);
    return 16'(la + (d >>> 16));   // >>> on a signed value = floor division
  endfunction

  function automatic logic [31:0] model_out();
    int ip, fr;
    logic [31:0] a, b;
    ip = int'(pos_m >>> 16);
    fr = int'(pos_m & 64'hFFFF);
    a  = samp[ip];
    b  = samp[ip+1];
    return {lerp_m(a[31:16], b[31:16], fr), lerp_m(a[15:0], b[15:0], fr)};
  endfunction

  task automatic write_s(input logic [15:0] i, input logic [15:0] q);
    mem[wr_abs % DEPTH] = {i, q};
    samp.push_back({i, q});
    wr_abs++;
    wr_ptr = wr_abs[AW:0];
  endtask

  task automatic do_reset(input logic [FW:0] s, input bit use_clear);
    step = s;
    if (use_clear) clear = 1'b1; else reset = 1'b1;
    #1;
    check("rst_ram_en", 64'(ram_en), 64'd0);
    tick();
    reset = 1'b0; clear = 1'b0;
    wr_abs = 0; wr_ptr = '0; samp.delete();
    pos_m = 0; step_m = s;
    axis.tready = 1'b0;
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_tdata",  64'(axis.tdata),  64'd0);
    check("rst_rd_ptr", 64'(rd_ptr),      64'd0);
  endtask

  // Keep at least two unread samples, occasionally topping up to full.
  task automatic feed();
    int ip;
    ip = int'(pos_m >>> 16);
    while (wr_abs < ip + 2) write_s(16'($urandom), 16'($urandom));
    while (wr_abs - ip < DEPTH && $urandom_range(0, 2) != 0) write_s(16'($urandom), 16'($urandom));
  endtask

  task automatic get_out(input string tag, input int stall, output logic [31:0] got);
    int k;
    longint ip;
    logic [31:0] exp;
    k = 0; got = '0;
    while (!axis.tvalid && k < 60) begin tick(); k++; end
    check({tag, "_valid"}, 64'(axis.tvalid), 64'd1);
    if (!axis.tvalid) return;
    ip  = pos_m >>> 16;
    exp = model_out();
    got = axis.tdata;
    check({tag, "_data"},   64'(axis.tdata), 64'(exp));
    check({tag, "_lat"},    64'(cyc - issue_cyc), ((ip % 16) == 15) ? 64'd4 : 64'd3);
    check({tag, "_rd_ptr"}, 64'(rd_ptr), 64'(ip[AW:0]));
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) tick();
      check({tag, "_hold_v"},  64'(axis.tvalid), 64'd1);
      check({tag, "_hold_d"},  64'(axis.tdata),  64'(got));
      check({tag, "_hold_rp"}, 64'(rd_ptr),      64'(ip[AW:0]));
    end
    axis.tready = 1'b1;
    tick();
    axis.tready = 1'b0;
    pos_m += longint'(step_m);
    ip = pos_m >>> 16;
    check({tag, "_drop_v"}, 64'(axis.tvalid), 64'd0);
    check({tag, "_adv_rp"}, 64'(rd_ptr), 64'(ip[AW:0]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [15:0] ei;
    int e0, w0;
    reset = 1'b0; clear = 1'b0; step = '0; wr_ptr = '0; axis.tready = 1'b0;
    wr_abs = 0; pos_m = 0; step_m = '0;
    tick();

    // Unit step: exact samples, third withheld until a fourth is written
    do_reset(17'h10000, 1'b0);
    write_s(16'd100, -16'sd100); write_s(16'd200, -16'sd200); write_s(16'd300, -16'sd300);
    get_out("u0", 0, got); check("u0_exact", 64'(got), 64'({16'd100, -16'sd100}));
    get_out("u1", 0, got); check("u1_exact", 64'(got), 64'({16'd200, -16'sd200}));
    repeat (20) tick();
    check("u2_withheld", 64'(axis.tvalid), 64'd0);
    check("u2_rd_ptr",   64'(rd_ptr),      64'd2);
    write_s(16'd400, -16'sd400);
    get_out("u2", 0, got); check("u2_exact", 64'(got), 64'({16'd300, -16'sd300}));

    // Occupancy 1: no fetch until another sample arrives
    e0 = en_count;
    repeat (20) tick();
    check("occ1_no_en", 64'(en_count - e0), 64'd0);
    write_s(16'd500, -16'sd500);
    #1;
    check("occ2_en", 64'(ram_en), 64'd1);
    get_out("u3", 0, got);

    // Half step
    do_reset(17'h08000, 1'b1);
    write_s(16'd0, 16'($urandom)); write_s(16'd1000, 16'($urandom)); write_s(16'd2000, 16'($urandom));
    for (int n = 0; n < 4; n++) begin
      get_out("half", 0, got);
      ei = 16'(n * 500);
      check("half_i", 64'(got[31:16]), 64'(ei));
    end

    // Quarter step between -1000 and 1000
    do_reset(17'h04000, 1'b0);
    write_s(-16'sd1000, 16'd7); write_s(16'd1000, 16'd7);
    for (int n = 0; n < 4; n++) begin
      get_out("qtr", 0, got);
      ei = 16'(-1000 + n * 500);
      check("qtr_i", 64'(got[31:16]), 64'(ei));
    end

    // Floor rounding: halfway between 0 and -1 is -1
    do_reset(17'h08000, 1'b0);
    write_s(16'd0, 16'd0); write_s(16'hFFFF, 16'hFFFF);
    get_out("flr0", 0, got);
    get_out("flr1", 0, got);
    check("flr_val", 64'(got), 64'h0000_0000_FFFF_FFFF);

    // Streaming 40 samples at unit step across buffer wraps, one long stall
    do_reset(17'h10000, 1'b0);
    w0 = wrap_reads;
    for (int n = 0; n < 40; n++) begin
      feed();
      get_out("strm", (n == 5) ? 10 : 0, got);
    end
    check("strm_wraps", 64'(wrap_reads - w0), 64'd2);

    // Random steps, including zero, with short random stalls
    for (int r = 0; r < 4; r++) begin
      do_reset((r == 0) ? 17'h0 : 17'($urandom_range(0, 17'h1FFFF)), r[0]);
      for (int n = 0; n < 30; n++) begin
        feed();
        get_out("rnd", $urandom_range(0, 2), got);
      end
    end

    // Reset while interpolating: sample dropped, new step takes effect
    do_reset(17'h10000, 1'b0);
    write_s(16'd10, 16'd20); write_s(16'd30, 16'd40);
    #1;
    e0 = 0;
    while (!ram_en && e0 < 20) begin tick(); e0++; end
    check("mid_issue", 64'(ram_en), 64'd1);
    tick(); tick();                  // now in the multiply cycle
    reset = 1'b1; step = 17'h08000;
    tick();
    reset = 1'b0;
    check("mid_tvalid", 64'(axis.tvalid), 64'd0);
    check("mid_rd_ptr", 64'(rd_ptr), 64'd0);
    pos_m = 0; step_m = 17'h08000;
    get_out("mid0", 0, got);
    get_out("mid1", 0, got);
    check("mid_step", 64'(got), 64'({16'd20, 16'd30}));

    check("no_en_while_valid", 64'(en_while_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
`default_nettype wire
